// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and the
// default operand width, which the ripple-carry adder wrapper also uses.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell; the only adding logic in the serial adder.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first.
// Produces {Cout,Sum} = A + B + Cin after WIDTH cycles with a one-cycle done.
// Optional macro SERIAL_ADDER_OVF_EN adds the registered signed Overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  // Holds the WIDTH-1 sum bits produced so far; the final bit joins on completion.
  logic [WIDTH-2:0] res_reg, res_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             done_reg, done_next;

  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] shifted_res;

  full_adder_1bit u_fa (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .cin  (carry_reg),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit    = (state_reg == ST_RUN) && (cnt_reg == LAST_BIT);
  assign shifted_res = {fa_sum, res_reg};

  // Next-state and datapath decisions for the two-state controller.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    done_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          a_next     = A;
          b_next     = B;
          carry_next = Cin;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        a_next     = {1'b0, a_reg[WIDTH-1:1]};
        b_next     = {1'b0, b_reg[WIDTH-1:1]};
        res_next   = shifted_res[WIDTH-1:1];
        carry_next = fa_cout;
        if (last_bit) begin
          // Counter is left at its final value so it never wraps.
          sum_next   = shifted_res;
          cout_next  = fa_cout;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand/result shift registers, carry, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      done_reg  <= done_next;
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = done_reg;
  assign Sum  = sum_reg;
  assign Cout = cout_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg, ovf_next;

  // Signed overflow: carry into the MSB xor carry out of it, captured at completion.
  always_comb begin
    ovf_next = ovf_reg;
    if (last_bit) begin
      ovf_next = carry_reg ^ fa_cout;
    end
  end

  // Overflow output register, held like Sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign Overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vectors plus random traffic, checked each
// cycle against a transaction-level model (A+B+Cin, WIDTH-cycle latency).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         Overflow;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .busy     (busy),
    .done     (done),
    .Sum      (Sum),
    .Cout     (Cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .Overflow (Overflow)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int op_count = 0;
  int done_seen = 0;

  // Reference model state
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  int           m_left = 0;
  logic [W:0]   m_pend = '0;
  logic         m_pend_ovf = 1'b0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_cin = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge: update the model from the inputs present at the edge,
  // then compare every output shortly after the edge.
  task automatic cycle();
    m_done = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_a        = A;
        m_b        = B;
        m_cin      = Cin;
        m_pend     = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
        m_pend_ovf = (A[W-1] == B[W-1]) && (m_pend[W-1] != A[W-1]);
        m_left     = W;
        m_busy     = 1'b1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_sum  = m_pend[W-1:0];
        m_cout = m_pend[W];
        m_ovf  = m_pend_ovf;
      end
    end
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("sum",  32'(Sum),  32'(m_sum));
    check("cout", 32'(Cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf",  32'(Overflow), 32'(m_ovf));
`endif
    if (done === 1'b1) done_seen++;
    if (m_done) begin
      op_count++;
      $display("op %0d: A=0x%02h B=0x%02h Cin=%0d -> Sum=0x%02h Cout=%0d", op_count, m_a, m_b, m_cin, Sum, Cout);
    end
  endtask

  // One operation from IDLE, with constant expectations checked in the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    A = a; B = b; Cin = cin; start = 1'b1;
    cycle();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    repeat (W) cycle();
    check("dir_done", 32'(done), 32'd1);
    check("dir_sum",  32'(Sum),  32'(exp_sum));
    check("dir_cout", 32'(Cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
    check("dir_ovf",  32'(Overflow), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check("dir_ovf_arg", 32'(exp_ovf), 32'd0);
`endif
    cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) cycle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum",  32'(Sum),  32'd0);
    rst = 1'b0;
    cycle();

    // Test plan vectors
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1);

    // start during RUN is ignored
    A = 8'h01; B = 8'h02; Cin = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    A = 8'h11; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (W - 3) cycle();
    check("ign_done", 32'(done), 32'd1);
    check("ign_sum",  32'(Sum),  32'h03);
    done_seen = 0;
    repeat (W + 2) cycle();
    check("ign_no_extra_done", 32'(done_seen), 32'd0);

    // reset in the middle of an operation
    A = 8'h33; B = 8'h44; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum",  32'(Sum),  32'd0);
    rst = 1'b0;
    done_seen = 0;
    repeat (W + 2) cycle();
    check("midrst_no_done", 32'(done_seen), 32'd0);
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

    // rst and start together: rst wins
    rst = 1'b1; start = 1'b1; A = 8'hAA; B = 8'h55;
    cycle();
    check("rst_start_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    cycle();

    // start held high: one result every W+1 cycles
    done_seen = 0;
    start = 1'b1;
    for (int i = 0; i < 5 * (W + 1); i++) begin
      A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
      cycle();
    end
    start = 1'b0;
    check("held_start_dones", 32'(done_seen), 32'd5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      A     = W'($urandom);
      B     = W'($urandom);
      Cin   = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0; start = 1'b0;
    repeat (W + 2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
